multi_cycle_ctrl: RTL and testbench

- Multi-cycle controller FSM that sequences the shared MIPS datapath (PC, IR, GRF, ALU, DM) over FETCH/DECODE/EXE/MEM/WB.
- Supports addu, subu, ori, lw, sw, lui, beq, jal, jr.
- Replaces the single-cycle decode path. Adds a DM request/ready handshake, so data memory may take a variable number of cycles.
- Sits between the IR (supplies op/fun) and the datapath enables/muxes.

---
 rtl/multi_cycle_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_multi_cycle_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_ctrl.sv
// rtl/multi_cycle_ctrl.sv - multi-cycle MIPS controller FSM (FETCH/DECODE/EXE/MEM/WB)
//
// Purpose: sequences the shared PC/IR/GRF/ALU/DM datapath for
//   addu, subu, ori, lui, lw, sw, beq, jal, jr. DM accesses use a req/ready
//   handshake, so MEM may last any number of cycles.
// Ports:
//   clk, reset            clock; synchronous active-high reset (FSM -> FETCH)
//   op, fun               IR[31:26] / IR[5:0], valid from DECODE onward
//   alu_zero              ALU zero flag, used by beq in EXE
//   dm_ready              DM handshake completion, only looked at in MEM
//   PCWrite, PCSrc        PC load enable and next-PC select
//   IRWrite               IR load enable
//   GRFWrite, GRFDst,     register-file write enable, destination select,
//   GRFSrc                write-data select
//   ALUSrc, signSrc, LUI  ALU B-operand select, extension mode, lui shift
//   ALUContrl             ALU operation
//   dm_req, DMWrite       DM request and write qualifier
//   instr_done            one-cycle pulse on the last cycle of each instruction
//   illegal               one-cycle pulse in DECODE for unsupported op/fun
//   state                 current state (debug)

module multi_cycle_ctrl #(
  parameter logic [4:0] JAL_REG = 5'd31
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] fun,
  input  logic       alu_zero,
  input  logic       dm_ready,
  output logic       PCWrite,
  output logic [1:0] PCSrc,
  output logic       IRWrite,
  output logic       GRFWrite,
  output logic [1:0] GRFDst,
  output logic [1:0] GRFSrc,
  output logic       ALUSrc,
  output logic       signSrc,
  output logic       LUI,
  output logic [2:0] ALUContrl,
  output logic       dm_req,
  output logic       DMWrite,
  output logic       instr_done,
  output logic       illegal,
  output logic [2:0] state
);

  // GRFDst=10 selects JAL_REG inside the datapath; $0 would silently drop the link.
  if (JAL_REG == 5'd0) begin : g_bad_jal_reg
    $error("JAL_REG must not be register 0");
  end

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXE    = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  state_t cur_state, next_state;

  logic is_rtype, is_addu, is_subu, is_jr, is_ori, is_lui, is_lw, is_sw, is_beq, is_jal;
  logic needs_exe;

  assign is_rtype  = (op == 6'b000000);
  assign is_addu   = is_rtype && (fun == 6'b100001);
  assign is_subu   = is_rtype && (fun == 6'b100011);
  assign is_jr     = is_rtype && (fun == 6'b001000);
  assign is_ori    = (op == 6'b001101);
  assign is_lui    = (op == 6'b001111);
  assign is_lw     = (op == 6'b100011);
  assign is_sw     = (op == 6'b101011);
  assign is_beq    = (op == 6'b000100);
  assign is_jal    = (op == 6'b000011);
  assign needs_exe = is_addu | is_subu | is_ori | is_lui | is_lw | is_sw | is_beq;

  always_ff @(posedge clk) begin
    if (reset) cur_state <= S_FETCH;
    else       cur_state <= next_state;
  end

  always_comb begin
    next_state = S_FETCH;
    PCWrite    = 1'b0;
    PCSrc      = 2'b00;
    IRWrite    = 1'b0;
    GRFWrite   = 1'b0;
    GRFDst     = 2'b00;
    GRFSrc     = 2'b00;
    ALUSrc     = 1'b0;
    signSrc    = 1'b0;
    LUI        = 1'b0;
    ALUContrl  = 3'b000;
    dm_req     = 1'b0;
    DMWrite    = 1'b0;
    instr_done = 1'b0;
    illegal    = 1'b0;

    case (cur_state)
      S_FETCH: begin
        IRWrite    = 1'b1;
        PCWrite    = 1'b1;
        next_state = S_DECODE;
      end
      S_DECODE: begin
        if (is_jal) begin
          PCWrite    = 1'b1;
          PCSrc      = 2'b10;
          GRFWrite   = 1'b1;
          GRFDst     = 2'b10;
          GRFSrc     = 2'b10;
          instr_done = 1'b1;
        end else if (is_jr) begin
          PCWrite    = 1'b1;
          PCSrc      = 2'b11;
          instr_done = 1'b1;
        end else if (needs_exe) begin
          next_state = S_EXE;
        end else begin
          // Unsupported encodings retire as a nop.
          illegal    = 1'b1;
          instr_done = 1'b1;
        end
      end
      S_EXE: begin
        if (is_addu || is_subu) begin
          ALUContrl  = is_subu ? 3'b001 : 3'b000;
          next_state = S_WB;
        end else if (is_ori || is_lui) begin
          // lui relies on the datapath feeding rs=$0, so OR passes the shifted immediate.
          ALUContrl  = 3'b010;
          ALUSrc     = 1'b1;
          LUI        = is_lui;
          next_state = S_WB;
        end else if (is_lw || is_sw) begin
          ALUSrc     = 1'b1;
          signSrc    = 1'b1;
          next_state = S_MEM;
        end else if (is_beq) begin
          ALUContrl  = 3'b001;
          signSrc    = 1'b1;
          PCSrc      = 2'b01;
          PCWrite    = alu_zero;
          instr_done = 1'b1;
        end
      end
      S_MEM: begin
        dm_req  = 1'b1;
        DMWrite = is_sw;
        if (!dm_ready) begin
          next_state = S_MEM;
        end else if (is_lw) begin
          next_state = S_WB;
        end else begin
          instr_done = 1'b1;
        end
      end
      S_WB: begin
        GRFWrite   = 1'b1;
        GRFDst     = is_rtype ? 2'b01 : 2'b00;
        GRFSrc     = is_lw ? 2'b01 : 2'b00;
        instr_done = 1'b1;
      end
      default: next_state = S_FETCH;
    endcase

    // Reset blanks every output immediately, so an in-flight DM request drops
    // in the same cycle reset is sampled.
    if (reset) begin
      PCWrite    = 1'b0;
      PCSrc      = 2'b00;
      IRWrite    = 1'b0;
      GRFWrite   = 1'b0;
      GRFDst     = 2'b00;
      GRFSrc     = 2'b00;
      ALUSrc     = 1'b0;
      signSrc    = 1'b0;
      LUI        = 1'b0;
      ALUContrl  = 3'b000;
      dm_req     = 1'b0;
      DMWrite    = 1'b0;
      instr_done = 1'b0;
      illegal    = 1'b0;
    end
  end

  assign state = reset ? 3'd0 : cur_state;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// tb/tb_multi_cycle_ctrl.sv - self-checking bench for multi_cycle_ctrl

module tb_multi_cycle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op, fun;
  logic       alu_zero, dm_ready;
  logic       PCWrite, IRWrite, GRFWrite, ALUSrc, signSrc, LUI;
  logic       dm_req, DMWrite, instr_done, illegal;
  logic [1:0] PCSrc, GRFDst, GRFSrc;
  logic [2:0] ALUContrl, state;

  multi_cycle_ctrl #(.JAL_REG(5'd31)) dut (
    .clk(clk), .reset(reset), .op(op), .fun(fun), .alu_zero(alu_zero),
    .dm_ready(dm_ready), .PCWrite(PCWrite), .PCSrc(PCSrc), .IRWrite(IRWrite),
    .GRFWrite(GRFWrite), .GRFDst(GRFDst), .GRFSrc(GRFSrc), .ALUSrc(ALUSrc),
    .signSrc(signSrc), .LUI(LUI), .ALUContrl(ALUContrl), .dm_req(dm_req),
    .DMWrite(DMWrite), .instr_done(instr_done), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pcw;
    logic [1:0] pcsrc;
    logic       irw;
    logic       grfw;
    logic [1:0] dst;
    logic [1:0] src;
    logic       alusrc;
    logic       sgn;
    logic       lui;
    logic [2:0] aluc;
    logic       req;
    logic       dmw;
    logic       done;
    logic       ill;
    logic [2:0] st;
  } ovec_t;

  typedef enum int {K_ADDU, K_SUBU, K_ORI, K_LUI, K_LW, K_SW, K_BEQ, K_JAL, K_JR, K_ILL} kind_t;

  ovec_t obs;
  assign obs = {PCWrite, PCSrc, IRWrite, GRFWrite, GRFDst, GRFSrc, ALUSrc, signSrc,
                LUI, ALUContrl, dm_req, DMWrite, instr_done, illegal, state};

  int n_checks = 0;
  int n_fail   = 0;

  // Phases: 0 fetch, 1 decode, 2 execute, 3 memory, 4 writeback.
  function automatic int instr_len(kind_t k, int waits);
    case (k)
      K_JAL, K_JR, K_ILL:         return 2;
      K_BEQ:                      return 3;
      K_SW:                       return 4 + waits;
      K_LW:                       return 5 + waits;
      default:                    return 4;
    endcase
  endfunction

  function automatic int phase_at(kind_t k, int idx, int waits);
    if (idx < 3 || k == K_JAL || k == K_JR || k == K_ILL || k == K_BEQ) return idx;
    if (k == K_SW) return 3;
    if (k == K_LW) return (idx < 4 + waits) ? 3 : 4;
    return 4;
  endfunction

  // Expected outputs for one cycle, straight from the per-instruction action tables.
  function automatic ovec_t model(kind_t k, int phase, logic ready, logic zero);
    ovec_t e = '0;
    e.st = 3'(phase);
    case (phase)
      0: begin e.irw = 1; e.pcw = 1; end
      1: case (k)
        K_JAL: begin e.pcw = 1; e.pcsrc = 2; e.grfw = 1; e.dst = 2; e.src = 2; e.done = 1; end
        K_JR:  begin e.pcw = 1; e.pcsrc = 3; e.done = 1; end
        K_ILL: begin e.ill = 1; e.done = 1; end
        default: ;
      endcase
      2: case (k)
        K_ADDU: e.aluc = 0;
        K_SUBU: e.aluc = 1;
        K_ORI:  begin e.aluc = 2; e.alusrc = 1; end
        K_LUI:  begin e.aluc = 2; e.alusrc = 1; e.lui = 1; end
        K_LW, K_SW: begin e.aluc = 0; e.alusrc = 1; e.sgn = 1; end
        K_BEQ:  begin e.aluc = 1; e.sgn = 1; e.pcsrc = 1; e.pcw = zero; e.done = 1; end
        default: ;
      endcase
      3: begin e.req = 1; e.dmw = (k == K_SW); e.done = (k == K_SW) && ready; end
      4: begin
        e.grfw = 1; e.done = 1;
        e.dst  = (k == K_ADDU || k == K_SUBU) ? 2'd1 : 2'd0;
        e.src  = (k == K_LW) ? 2'd1 : 2'd0;
      end
      default: ;
    endcase
    return e;
  endfunction

  function automatic logic [11:0] legal_opfun(kind_t k);
    logic [5:0] r;
    r = 6'($urandom);
    case (k)
      K_ADDU: return {6'd0, 6'b100001};
      K_SUBU: return {6'd0, 6'b100011};
      K_JR:   return {6'd0, 6'b001000};
      K_ORI:  return {6'b001101, r};
      K_LUI:  return {6'b001111, r};
      K_LW:   return {6'b100011, r};
      K_SW:   return {6'b101011, r};
      K_BEQ:  return {6'b000100, r};
      default: return {6'b000011, r};
    endcase
  endfunction

  function automatic logic [11:0] illegal_opfun();
    logic [5:0] o, f;
    forever begin
      o = 6'($urandom);
      f = 6'($urandom);
      if (o == 6'd0) begin
        if (f != 6'b100001 && f != 6'b100011 && f != 6'b001000) return {o, f};
      end else if (o != 6'd3 && o != 6'd4 && o != 6'd13 && o != 6'd15 &&
                   o != 6'd35 && o != 6'd43) begin
        return {o, f};
      end
    end
  endfunction

  // Runs one instruction cycle by cycle. zmode 0/1 forces alu_zero, otherwise random.
  // abort_at >= 0 asserts reset on that cycle index and abandons the instruction.
  task automatic run_instr(input kind_t k, input logic [11:0] of, input int waits,
                           input int zmode, input int abort_at, input string name);
    int   len, ph, mcount;
    ovec_t exp_v;
    len    = instr_len(k, waits);
    mcount = 0;
    for (int idx = 0; idx < len; idx++) begin
      @(negedge clk);
      ph = phase_at(k, idx, waits);
      if (ph == 0) begin
        op  = 6'($urandom);
        fun = 6'($urandom);
      end else begin
        op  = of[11:6];
        fun = of[5:0];
      end
      alu_zero = (zmode == 0 || zmode == 1) ? zmode[0] : 1'($urandom);
      if (ph == 3) begin
        dm_ready = (mcount == waits);
        mcount++;
      end else begin
        dm_ready = 1'($urandom);
      end
      if (idx == abort_at) begin
        reset = 1'b1;
        #1;
        n_checks++;
        if (obs !== '0) begin
          n_fail++;
          $display("FAIL %s reset_abort cycle %0d: got %h expected %h", name, idx, obs, 22'h0);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        return;
      end
      reset = 1'b0;
      #1;
      exp_v = model(k, ph, dm_ready, alu_zero);
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL %s cycle %0d: got %h expected %h", name, idx, obs, exp_v);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      op = 6'($urandom); fun = 6'($urandom);
      alu_zero = 1'($urandom); dm_ready = 1'($urandom);
      #1;
      n_checks++;
      if (obs !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs cycle %0d: got %h expected %h", i, obs, 22'h0);
      end
    end
    @(posedge clk);
    #1 reset = 1'b0;
    // First cycle after release must be FETCH; checked as cycle 0 of this addu.
    run_instr(K_ADDU, legal_opfun(K_ADDU), 0, 2, -1, "reset_release_addu");
  endtask

  task automatic test_addu();
    run_instr(K_ADDU, legal_opfun(K_ADDU), 0, 2, -1, "addu");
    run_instr(K_SUBU, legal_opfun(K_SUBU), 0, 2, -1, "subu");
    run_instr(K_ORI,  legal_opfun(K_ORI),  0, 2, -1, "ori");
    run_instr(K_LUI,  legal_opfun(K_LUI),  0, 2, -1, "lui");
  endtask

  task automatic test_lw_wait();
    run_instr(K_LW, legal_opfun(K_LW), 3, 2, -1, "lw_wait3");
  endtask

  task automatic test_sw_beq();
    run_instr(K_SW,  legal_opfun(K_SW),  0, 2, -1, "sw_nowait");
    run_instr(K_BEQ, legal_opfun(K_BEQ), 0, 0, -1, "beq_not_taken");
    run_instr(K_BEQ, legal_opfun(K_BEQ), 0, 1, -1, "beq_taken");
  endtask

  task automatic test_jal_jr_illegal();
    run_instr(K_JAL, legal_opfun(K_JAL), 0, 2, -1, "jal");
    run_instr(K_JR,  legal_opfun(K_JR),  0, 2, -1, "jr");
    run_instr(K_ILL, {6'b111111, 6'($urandom)}, 0, 2, -1, "illegal_op3f");
  endtask

  task automatic test_reset_mid_mem();
    // Cycles 0..2 are FETCH/DECODE/EXE, 3 and 4 are stalled MEM, reset lands on 5.
    run_instr(K_LW, legal_opfun(K_LW), 5, 2, 5, "lw_reset_in_mem");
    run_instr(K_ADDU, legal_opfun(K_ADDU), 0, 2, -1, "after_mem_reset");
  endtask

  task automatic test_random();
    kind_t k;
    logic [11:0] of;
    for (int n = 0; n < 60; n++) begin
      k  = kind_t'($urandom_range(0, 9));
      of = (k == K_ILL) ? illegal_opfun() : legal_opfun(k);
      run_instr(k, of, int'($urandom_range(0, 3)), 2, -1, "random");
    end
  endtask

  task automatic test_back_to_back();
    run_instr(K_SW, legal_opfun(K_SW), 2, 2, -1, "b2b_sw_wait2");
    run_instr(K_LW, legal_opfun(K_LW), 0, 2, -1, "b2b_lw_nowait");
    run_instr(K_JR, legal_opfun(K_JR), 0, 2, -1, "b2b_jr");
  endtask

  initial begin
    reset = 1'b1; op = '0; fun = '0; alu_zero = 1'b0; dm_ready = 1'b0;
    test_reset();
    test_addu();
    test_lw_wait();
    test_sw_beq();
    test_jal_jr_illegal();
    test_reset_mid_mem();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
